dbus_store_buffer: RTL and testbench
====================================

# dbus_store_buffer

Posted-write buffer between the core's data-bus master port (`dreq`/`dresp`) and the data memory/cache port. Stores are acknowledged to the core in the same cycle and drained in order to memory; loads pass through to memory only once every buffered store has completed. This removes store latency from the Memory stage without reordering memory accesses.

## Interface
Parameters:
- `DEPTH`, 4: store entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `creq`  in  `dbus_req_t`  core request: `valid`, `addr[31:0]`, `size`, `strobe[3:0]`, `data[31:0]`. Nonzero `strobe` means store, zero means load.
- `cresp`  out  `dbus_resp_t`  to core: `addr_ok`, `data_ok`, `data[31:0]`.
- `mreq`  out  `dbus_req_t`  to memory.
- `mresp`  in  `dbus_resp_t`  from memory.
- `drained`  out  1  high when the FIFO is empty and the state is IDLE.

## Operation
- Bus rules, both sides: master holds `valid` and payload stable until `addr_ok`. `data_ok` arrives in the same cycle as `addr_ok` or later. At most one transaction is outstanding per side.
- FIFO: `DEPTH` entries of {addr, size, strobe, data}.
  - `head` and `tail` pointers wrap modulo `DEPTH`.
  - `count` has width $clog2(DEPTH)+1.
- States:
  - `IDLE`: no memory transaction outstanding.
  - `ST_ADDR`: head entry presented on `mreq`.
  - `ST_DATA`: store address accepted, waiting for `data_ok`.
  - `LD_DATA`: load address accepted, waiting for `data_ok`.
- Store acceptance:
  - Condition: `creq.valid`, store, `count<DEPTH`, state ≠ `LD_DATA`.
  - Response: `cresp.addr_ok=cresp.data_ok=1` combinationally; entry written at `tail` on the clock edge.
  - Full FIFO: `addr_ok=0`; the core holds the request.
- Load acceptance:
  - Only in `IDLE` with `count==0`.
  - Then `mreq=creq` combinationally and `cresp.addr_ok=mresp.addr_ok`.
  - On `addr_ok`: go to `LD_DATA`, unless `data_ok` is also high that cycle, in which case stay in `IDLE`.
  - Otherwise the load sees `addr_ok=0`.
- `LD_DATA`: `mreq.valid=0`; `cresp.data_ok=mresp.data_ok`; `cresp.data=mresp.data`. On `data_ok` go to `IDLE`.
- Drain:
  - `IDLE` with `count>0` goes to `ST_ADDR` on the next edge. Drain has priority over a waiting load.
  - `ST_ADDR`: `mreq` = entry at `head`, `valid=1`.
  - On `addr_ok`, go to `ST_DATA`.
  - If `addr_ok` and `data_ok` arrive together: pop, then go to `ST_ADDR` if entries remain, else `IDLE`.
  - `ST_DATA`: `mreq.valid=0`. On `data_ok`: pop `head`, then go to `ST_ADDR` if `count-1>0`, else `IDLE`.
- Simultaneous push and pop: `count` is unchanged, both pointers advance, and the popped and pushed slots are distinct. A push into an empty FIFO cannot pop in the same cycle.
- `cresp.data` is zero except in `LD_DATA` and during a load pass-through.
- Store `data_ok` never overlaps load `data_ok`: stores are refused in `LD_DATA`.

## Timing
- Reset values: state `IDLE`; `head=tail=count=0`; `mreq` all zero; `cresp` all zero; `drained=1`.
- Reset asserted mid-transaction clears everything asynchronously and drops the outstanding memory transaction; the memory side is reset in the same domain.
- Store to core: 0-cycle acknowledge.
- First drain `mreq.valid`: one cycle after the push edge.
- Load: earliest `addr_ok` is in the cycle after `drained` rises. Data latency equals memory latency, with no added register stage.
- `mreq` in `ST_ADDR` is driven from registered FIFO contents and is stable until `addr_ok`.
- Back-to-back drain with a single-cycle memory (`addr_ok` and `data_ok` together): one store per cycle.

## Structure
- In the `mycpu.svh` package:
  - `sbuf_entry_t` {addr, size, strobe, data}.
  - `sbuf_state_t` enum {IDLE, ST_ADDR, ST_DATA, LD_DATA}.
  - `SBUF_DEPTH` default.
- Sub-module `sbuf_fifo`: storage, `head`/`tail`/`count`, push/pop, `full`/`empty`.
- The parent `dbus_store_buffer` holds the state machine and the bus muxing.

## Test plan
- Single store `addr=0x80000010`, `strobe=4'hF`, `data=0xDEADBEEF`, memory latency 2 → core `addr_ok`/`data_ok` same cycle; `mreq.valid` the next cycle; pop after `data_ok`; `drained` back to 1.
- 5 stores with `DEPTH=4` and memory stalling `addr_ok` → the 5th store sees `addr_ok=0` until the first pop; the 5 writes reach memory in program order.
- Store to `0x100` followed by a load from `0x100` → the load's `addr_ok` stays 0 until the store's `data_ok`; the load returns the memory's value `0x12345678`.
- Single-cycle memory with 8 consecutive stores → one memory write per cycle; `count` never exceeds 1; pointers wrap correctly past index 3.
- `resetn` pulled low asynchronously while in `ST_DATA` with 3 entries queued → `mreq.valid`, `cresp`, `count` all 0 immediately; state `IDLE`; `drained=1`.
- Load with memory giving `addr_ok` and `data_ok` in the same cycle, `data=0xCAFEF00D` → `cresp.addr_ok`, `data_ok` and `data` in that cycle; state remains `IDLE`.

Source files
------------

// File: rtl/dbus_store_buffer_pkg.sv
// Shared types for the data-bus store buffer: bus request/response payloads,
// FIFO entry layout and drain/load state encoding.
package dbus_store_buffer_pkg;

  localparam int unsigned SBUF_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } sbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ST_ADDR,
    ST_DATA,
    LD_DATA
  } sbuf_state_t;

  function automatic sbuf_entry_t req_to_entry(input dbus_req_t r);
    sbuf_entry_t e;
    e.addr   = r.addr;
    e.size   = r.size;
    e.strobe = r.strobe;
    e.data   = r.data;
    return e;
  endfunction

  function automatic dbus_req_t entry_to_req(input sbuf_entry_t e);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = e.addr;
    r.size   = e.size;
    r.strobe = e.strobe;
    r.data   = e.data;
    return r;
  endfunction

endpackage

// File: rtl/dbus_store_buffer_if.sv
// Data-bus channel: request flows master->slave, response slave->master.
interface dbus_store_buffer_if;
  import dbus_store_buffer_pkg::*;

  dbus_req_t  req;
  dbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_store_buffer_fifo.sv
// Store-entry FIFO: power-of-two ring with head/tail pointers and an
// occupancy counter one bit wider than the pointers.
module sbuf_fifo
  import dbus_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SBUF_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  sbuf_entry_t wr_entry,
  input  logic        pop,
  output sbuf_entry_t head_entry,
  output logic        full,
  output logic        empty,
  output logic        last
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW + 1)'(1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  sbuf_entry_t   mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_entry;
  end

  assign head_entry = mem[head];
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign last       = (count == ONE_CNT);

endmodule

// File: rtl/dbus_store_buffer.sv
// Posted-write buffer: stores are acknowledged immediately and drained in
// order; loads go to memory only once every buffered store has completed.
module dbus_store_buffer
  import dbus_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SBUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       resetn,
  dbus_store_buffer_if.slave         cbus,
  dbus_store_buffer_if.master        mbus,
  output logic                       drained
);

  sbuf_state_t state_q;
  sbuf_state_t state_d;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        last;
  logic        store_req;
  logic        load_req;
  logic        load_pass;
  logic        remain;
  sbuf_entry_t head_entry;
  dbus_req_t   mreq_d;
  dbus_resp_t  cresp_d;

  sbuf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .wr_entry   (req_to_entry(cbus.req)),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .last       (last)
  );

  assign store_req = cbus.req.valid && (cbus.req.strobe != '0);
  assign load_req  = cbus.req.valid && (cbus.req.strobe == '0);
  // Outputs are forced quiet while reset is held so a request the core keeps
  // asserting cannot be acknowledged or forwarded.
  assign push      = resetn && store_req && !full && (state_q != LD_DATA);
  assign load_pass = resetn && load_req && (state_q == IDLE) && empty;
  // A same-cycle push keeps the drain going even when the head is the last entry.
  assign remain    = !last || push;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    mreq_d  = '0;
    cresp_d = '0;

    if (push) begin
      cresp_d.addr_ok = 1'b1;
      cresp_d.data_ok = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!empty || push) begin
          state_d = ST_ADDR;
        end else if (load_pass) begin
          mreq_d          = cbus.req;
          cresp_d.addr_ok = mbus.resp.addr_ok;
          cresp_d.data_ok = mbus.resp.addr_ok && mbus.resp.data_ok;
          cresp_d.data    = mbus.resp.data;
          if (mbus.resp.addr_ok && !mbus.resp.data_ok) state_d = LD_DATA;
        end
      end
      ST_ADDR: begin
        mreq_d = entry_to_req(head_entry);
        if (mbus.resp.addr_ok) begin
          if (mbus.resp.data_ok) begin
            pop     = 1'b1;
            state_d = remain ? ST_ADDR : IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (mbus.resp.data_ok) begin
          pop     = 1'b1;
          state_d = remain ? ST_ADDR : IDLE;
        end
      end
      LD_DATA: begin
        cresp_d.data_ok = mbus.resp.data_ok;
        cresp_d.data    = mbus.resp.data;
        if (mbus.resp.data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!resetn) begin
      mreq_d  = '0;
      cresp_d = '0;
    end
  end

  assign mbus.req  = mreq_d;
  assign cbus.resp = cresp_d;
  assign drained   = empty && (state_q == IDLE);

endmodule

// File: tb/tb_dbus_store_buffer.sv
// Scoreboard bench for dbus_store_buffer: a behavioural memory on the far side,
// directed scenarios followed by randomized store/load traffic.
module tb_dbus_store_buffer;
  import dbus_store_buffer_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic drained;
  always #5 clk = ~clk;

  dbus_store_buffer_if cbus ();
  dbus_store_buffer_if mbus ();

  dbus_store_buffer #(.DEPTH(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .cbus    (cbus),
    .mbus    (mbus),
    .drained (drained)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  int unsigned lat       = 2;   // 0: addr_ok and data_ok in the same cycle
  int unsigned allow_pct = 100;
  logic        m_busy, m_pst, m_allow, m_acc;
  int unsigned m_wait;
  logic [31:0] m_pdata;
  logic [31:0] mem [64];

  function automatic logic [31:0] init_word(input int unsigned i);
    return 32'h1000_0000 + i;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] s,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    m_acc = mbus.req.valid && !m_busy && m_allow;
    mbus.resp = '0;
    mbus.resp.addr_ok = m_acc;
    if (m_busy && m_wait == 0) begin
      mbus.resp.data_ok = 1'b1;
      mbus.resp.data    = m_pdata;
    end else if (lat == 0 && m_acc) begin
      mbus.resp.data_ok = 1'b1;
      if (mbus.req.strobe == '0) mbus.resp.data = mem[mbus.req.addr[7:2]];
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy  <= 1'b0;
      m_pst   <= 1'b0;
      m_wait  <= 0;
      m_pdata <= '0;
      m_allow <= 1'b1;
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else begin
      if (m_busy) begin
        if (m_wait == 0) m_busy <= 1'b0;
        else             m_wait <= m_wait - 1;
      end
      if (m_acc) begin
        if (mbus.req.strobe != '0)
          mem[mbus.req.addr[7:2]] <= merge(mem[mbus.req.addr[7:2]], mbus.req.strobe, mbus.req.data);
        if (lat != 0) begin
          m_busy  <= 1'b1;
          m_wait  <= lat - 1;
          m_pst   <= (mbus.req.strobe != '0);
          m_pdata <= (mbus.req.strobe == '0) ? mem[mbus.req.addr[7:2]] : '0;
        end
      end
      m_allow <= ($urandom_range(99, 0) < allow_pct);
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [64];
  logic [67:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_la [$];
  int          wr_cyc [$];
  int          n_st_acc  = 0;
  int          n_st_done = 0;
  logic        ld_wait;

  task automatic ref_init();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rd(input logic [31:0] d);
    if (exp_rd.size() == 0) begin
      total++; bad++;
      $display("FAIL ld_extra: got load data %h expected no load", d);
    end else chk("ld_data", d, exp_rd.pop_front());
  endtask

  initial begin
    ld_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) ld_wait = 1'b0;
      else begin
        if (mbus.req.valid && mbus.resp.addr_ok) begin
          if (mbus.req.strobe != '0) begin
            wr_cyc.push_back(cyc);
            if (exp_wr.size() == 0) begin
              total++; bad++;
              $display("FAIL wr_extra: got write %h expected none", mbus.req.addr);
            end else chk("wr_order", {mbus.req.addr, mbus.req.strobe, mbus.req.data}, exp_wr.pop_front());
          end else begin
            chk("ld_order", n_st_done, n_st_acc);
            if (exp_la.size() == 0) begin
              total++; bad++;
              $display("FAIL ld_addr_extra: got load %h expected none", mbus.req.addr);
            end else chk("ld_addr", mbus.req.addr, exp_la.pop_front());
          end
        end
        if (mbus.resp.data_ok && ((m_busy && m_pst) || (lat == 0 && m_acc && mbus.req.strobe != '0)))
          n_st_done++;

        if (cbus.req.valid && cbus.req.strobe == '0 && cbus.resp.addr_ok) begin
          if (cbus.resp.data_ok) chk_rd(cbus.resp.data);
          else                   ld_wait = 1'b1;
        end else if (ld_wait && cbus.resp.data_ok) begin
          chk_rd(cbus.resp.data);
          ld_wait = 1'b0;
        end else chk("data_zero", cbus.resp.data, 0);
      end
    end
  end

  // ---------------- core-side driver (tasks start and end at posedge+1) ----------------
  task automatic st_drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cbus.req.valid  = 1'b1;
    cbus.req.addr   = a;
    cbus.req.size   = 2'd2;
    cbus.req.strobe = s;
    cbus.req.data   = d;
  endtask

  task automatic st_issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    st_drive(a, s, d);
    ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], s, d);
    exp_wr.push_back({a, s, d});
  endtask

  task automatic wait_ack(input string nm, output logic ok, output logic same);
    int n;
    n = 0;
    @(negedge clk);
    while (!cbus.resp.addr_ok && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok   = cbus.resp.addr_ok;
    same = cbus.resp.data_ok;
    chk(nm, ok, 1);
    @(posedge clk);
    #1 cbus.req = '0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic ok, same;
    st_issue(a, s, d);
    wait_ack("st_accept", ok, same);
    chk("st_ack_same", same, 1);
    if (ok) n_st_acc++;
  endtask

  task automatic do_load(input logic [31:0] a, output logic same, output logic [31:0] d);
    logic ok;
    int   n;
    cbus.req.valid  = 1'b1;
    cbus.req.addr   = a;
    cbus.req.size   = 2'd2;
    cbus.req.strobe = 4'h0;
    cbus.req.data   = '0;
    exp_rd.push_back(ref_mem[a[7:2]]);
    exp_la.push_back(a);
    n = 0;
    @(negedge clk);
    while (!cbus.resp.addr_ok && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok   = cbus.resp.addr_ok;
    same = cbus.resp.data_ok;
    d    = cbus.resp.data;
    chk("ld_accept", ok, 1);
    @(posedge clk);
    #1 cbus.req = '0;
    if (ok && !same) begin
      n = 0;
      @(negedge clk);
      while (!cbus.resp.data_ok && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("ld_done", cbus.resp.data_ok, 1);
      d = cbus.resp.data;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    @(negedge clk);
    while (!drained && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drained", drained, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        same, ok;
    logic [31:0] d;
    int          c0;
    int unsigned ph_lat [4] = '{1, 3, 0, 2};
    int unsigned ph_pct [4] = '{70, 50, 100, 40};

    cbus.req = '0;
    ref_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_drained", drained, 1);
    chk("rst_mreq", mbus.req, 0);
    chk("rst_cresp", cbus.resp, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // single store, memory latency 2
    lat = 2;
    allow_pct = 100;
    do_store(32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("first_drain_valid", mbus.req.valid, 1);
    chk("first_drain_addr", mbus.req.addr, 32'h8000_0010);
    @(posedge clk);
    #1;
    wait_drained();

    // five stores against a stalled memory
    allow_pct = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) do_store(32'h140 + 4 * i, 4'hF, 32'hA0A0_0000 + i);
    st_issue(32'h150, 4'h3, 32'h0BAD_F00D);
    repeat (3) begin
      @(negedge clk);
      chk("full_hold", cbus.resp.addr_ok, 0);
    end
    allow_pct = 100;
    wait_ack("full_ack", ok, same);
    if (ok) n_st_acc++;
    wait_drained();

    // store then load from the same address
    do_store(32'h100, 4'hF, 32'h1234_5678);
    do_load(32'h100, same, d);
    chk("ld_after_st", d, 32'h1234_5678);
    wait_drained();

    // single-cycle memory, eight back-to-back stores
    lat = 0;
    wr_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) do_store(32'h180 + 4 * i, 4'hF, 32'h5000_0000 + i);
    wait_drained();
    chk("b2b_count", wr_cyc.size(), 8);
    for (int i = 0; i < wr_cyc.size(); i++) chk("b2b_cycle", wr_cyc[i], c0 + 1 + i);

    // load with same-cycle addr_ok/data_ok
    do_store(32'h104, 4'hF, 32'hCAFE_F00D);
    wait_drained();
    do_load(32'h104, same, d);
    chk("ld_fast_same", same, 1);
    chk("ld_fast_data", d, 32'hCAFE_F00D);
    @(negedge clk);
    chk("ld_fast_idle", drained, 1);
    @(posedge clk);
    #1;

    // asynchronous reset while a store waits for data_ok
    lat = 6;
    for (int i = 0; i < 3; i++) do_store(32'h1C0 + 4 * i, 4'hF, 32'h7700_0000 + i);
    st_drive(32'h1D0, 4'hF, 32'h0000_0055);
    #2;
    chk("pre_rst_busy", drained, 0);
    resetn = 1'b0;
    #1;
    chk("arst_mreq_valid", mbus.req.valid, 0);
    chk("arst_cresp", cbus.resp, 0);
    chk("arst_drained", drained, 1);
    cbus.req = '0;
    exp_wr.delete();
    ref_init();
    n_st_acc  = 0;
    n_st_done = 0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic across several memory behaviours
    for (int p = 0; p < 4; p++) begin
      wait_drained();
      lat       = ph_lat[p];
      allow_pct = ph_pct[p];
      @(posedge clk);
      #1;
      for (int k = 0; k < 60; k++) begin
        logic [31:0] a;
        logic [3:0]  s;
        a = 32'h200 + 4 * $urandom_range(15, 0);
        if ($urandom_range(9, 0) < 6) begin
          s = 4'($urandom_range(15, 1));
          do_store(a, s, $urandom);
        end else begin
          do_load(a, same, d);
        end
        repeat ($urandom_range(2, 0)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_drained();
    chk("end_queues_empty", exp_wr.size() + exp_rd.size() + exp_la.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
